// File: rtl/riscy_mem_arbiter.sv
// -----------------------------------------------------------------------------
// riscy_mem_arbiter
// Shares one line-wide memory port between the instruction cache (read only)
// and the data cache (read / write-back). One line transaction is in flight at
// a time. When both caches request in the same cycle, a round-robin pointer
// picks the winner.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   i_read, i_addr        icache line read request and line address
//   i_rdata, i_resp       line returned to icache, completion pulse
//   d_read, d_write       dcache line read / write-back request
//   d_addr, d_wdata       dcache line address and write-back data
//   d_rdata, d_resp       line returned to dcache, completion pulse
//   m_read, m_write       registered memory read / write strobes
//   m_addr, m_wdata       registered memory address / write data
//   m_rdata, m_resp       memory read data, completion pulse
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no transaction; arbitrate pending requests
// I_BUSY | icache line read outstanding on the memory port
// D_BUSY | dcache line read or write-back outstanding on the memory port
// DONE   | one-cycle gap so the served requester can drop its request
// -----------------------------------------------------------------------------
module riscy_mem_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned LINE_WIDTH   = 256,
   parameter bit          ICACHE_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   output logic                  m_read,
   output logic                  m_write,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [LINE_WIDTH-1:0] m_wdata,
   input  logic [LINE_WIDTH-1:0] m_rdata,
   input  logic                  m_resp
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                state_q,   state_d;
   logic                  rr_ptr_q,  rr_ptr_d;
   logic                  m_read_q,  m_read_d;
   logic                  m_write_q, m_write_d;
   logic [ADDR_WIDTH-1:0] m_addr_q,  m_addr_d;
   logic [LINE_WIDTH-1:0] m_wdata_q, m_wdata_d;

   logic i_req;
   logic d_req;
   logic grant_i;
   logic grant_d;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   // rr_ptr_q = 1 favours the icache on a simultaneous request.
   assign grant_i = i_req & (~d_req | rr_ptr_q);
   assign grant_d = d_req & (~i_req | ~rr_ptr_q);

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      m_read_d  = m_read_q;
      m_write_d = m_write_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;

      case (state_q)
         IDLE: begin
            if (grant_i) begin
               state_d  = I_BUSY;
               rr_ptr_d = 1'b0;
               m_read_d = 1'b1;
               m_addr_d = i_addr;
            end else if (grant_d) begin
               state_d  = D_BUSY;
               rr_ptr_d = 1'b1;
               m_addr_d = d_addr;
               // A simultaneous read+write is resolved as a write-back.
               if (d_write) begin
                  m_write_d = 1'b1;
                  m_wdata_d = d_wdata;
               end else begin
                  m_read_d  = 1'b1;
               end
            end
         end
         I_BUSY, D_BUSY: begin
            if (m_resp) begin
               state_d   = DONE;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= ICACHE_FIRST;
         m_read_q  <= 1'b0;
         m_write_q <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         m_read_q  <= m_read_d;
         m_write_q <= m_write_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
      end
   end

   assign m_read  = m_read_q;
   assign m_write = m_write_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;

   // Completion is routed combinationally so the requester sees it in the
   // same cycle memory reports it.
   assign i_resp  = (state_q == I_BUSY) & m_resp;
   assign d_resp  = (state_q == D_BUSY) & m_resp;
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;

endmodule

// File: tb/tb_riscy_mem_arbiter.sv
module tb_riscy_mem_arbiter;

   typedef struct packed {
      logic [31:0]  addr;
      logic         wr;
      logic [255:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_read = 1'b0;
   logic [31:0]  i_addr = '0;
   logic [255:0] i_rdata;
   logic         i_resp;
   logic         d_read = 1'b0;
   logic         d_write = 1'b0;
   logic [31:0]  d_addr = '0;
   logic [255:0] d_wdata = '0;
   logic [255:0] d_rdata;
   logic         d_resp;
   logic         m_read;
   logic         m_write;
   logic [31:0]  m_addr;
   logic [255:0] m_wdata;
   logic [255:0] m_rdata = '0;
   logic         m_resp = 1'b0;

   int total = 0;
   int bad   = 0;
   int req_cnt = 0;
   int txn_cnt = 0;
   int mem_lat = 5;
   int spur_cnt = 0;
   int spur_done = 0;

   exp_t i_exp_q[$];
   exp_t d_exp_q[$];
   exp_t mon_e;

   logic [255:0] ref_mem [logic [31:0]];
   logic [255:0] mem_arr [logic [31:0]];

   localparam logic [255:0] W1 = {8{32'h12345678}};
   localparam logic [255:0] W2 = {8{32'hDEADBEEF}};

   always #5 clk = ~clk;

   riscy_mem_arbiter #(
      .ADDR_WIDTH  (32),
      .LINE_WIDTH  (256),
      .ICACHE_FIRST(1'b1)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_read  (i_read),
      .i_addr  (i_addr),
      .i_rdata (i_rdata),
      .i_resp  (i_resp),
      .d_read  (d_read),
      .d_write (d_write),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_rdata (d_rdata),
      .d_resp  (d_resp),
      .m_read  (m_read),
      .m_write (m_write),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata),
      .m_resp  (m_resp)
   );

   // Power-on contents of every line; 0x40 holds the A5 pattern.
   function automatic logic [255:0] init_line(input logic [31:0] a);
      logic [255:0] v;
      v = '0;
      if (a == 32'h40) begin
         v = {32{8'hA5}};
      end else begin
         for (int k = 0; k < 8; k++) v[k*32 +: 32] = (a * 32'h9E3779B1) + 32'(k);
      end
      return v;
   endfunction

   function automatic logic [255:0] ref_get(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic push_i(input logic [31:0] a);
      exp_t e;
      e.addr = a; e.wr = 1'b0; e.data = ref_get(a);
      i_exp_q.push_back(e);
      req_cnt++;
   endtask

   task automatic push_d(input logic [31:0] a, input bit wr, input logic [255:0] wd);
      exp_t e;
      e.addr = a; e.wr = wr;
      if (wr) begin
         e.data = wd;
         ref_mem[a] = wd;
      end else begin
         e.data = ref_get(a);
      end
      d_exp_q.push_back(e);
      req_cnt++;
   endtask

   task automatic wait_resp(input bit is_i);
      int n;
      n = 0;
      while (((is_i ? i_resp : d_resp) !== 1'b1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         total++; bad++;
         $display("FAIL %s_resp_timeout: got no resp in 300 cycles, required one", is_i ? "i" : "d");
      end
   endtask

   // Requester behaviour: hold the request through the resp edge, drop after.
   task automatic i_txn(input logic [31:0] a, input int gap);
      repeat (gap) @(negedge clk);
      push_i(a);
      i_read = 1'b1; i_addr = a;
      wait_resp(1'b1);
      @(negedge clk);
      i_read = 1'b0;
   endtask

   task automatic d_txn(input logic [31:0] a, input bit wr, input logic [255:0] wd, input int gap);
      repeat (gap) @(negedge clk);
      push_d(a, wr, wd);
      d_read = !wr; d_write = wr; d_addr = a; d_wdata = wd;
      wait_resp(1'b0);
      @(negedge clk);
      d_read = 1'b0; d_write = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Memory model: serves whatever the arbiter presents, checks the request
   // stays stable, counts transactions, and can inject a stray m_resp.
   logic [31:0]  s_addr;
   logic         s_wr;
   logic [255:0] s_wd;
   bit           s_ok;
   int           s_lat;
   always begin
      @(negedge clk);
      if (rst_n && (m_read || m_write)) begin
         s_addr = m_addr; s_wr = m_write; s_wd = m_wdata; s_ok = 1'b1;
         txn_cnt++;
         s_lat = (mem_lat == 0) ? int'($urandom_range(1, 6)) : mem_lat;
         for (int k = 1; k < s_lat; k++) begin
            @(negedge clk);
            if (!rst_n || !(m_read || m_write)) begin
               s_ok = 1'b0;
               break;
            end
            chk("m_addr_hold", 256'(m_addr), 256'(s_addr));
            chk("m_op_hold", 256'({m_read, m_write}), 256'({!s_wr, s_wr}));
            if (s_wr) chk("m_wdata_hold", m_wdata, s_wd);
         end
         if (s_ok) begin
            @(posedge clk); #1;
            if (rst_n) begin
               m_resp = 1'b1;
               if (s_wr) mem_arr[s_addr] = s_wd;
               else m_rdata = mem_arr.exists(s_addr) ? mem_arr[s_addr] : init_line(s_addr);
            end
            @(posedge clk); #1;
            m_resp = 1'b0;
         end
      end else if (rst_n && spur_cnt != spur_done) begin
         @(posedge clk); #1;
         m_resp = 1'b1; m_rdata = {8{32'hBAD0BAD0}};
         @(posedge clk); #1;
         m_resp = 1'b0;
         spur_done++;
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst_n) begin
         i_exp_q.delete();
         d_exp_q.delete();
      end else begin
         if (d_read && d_write) begin
            total++; bad++;
            $display("FAIL illegal_d_rw: got d_read=1 d_write=1, required at most one");
         end
         if (i_resp && d_resp) begin
            total++; bad++;
            $display("FAIL both_resp: got i_resp=1 d_resp=1, required at most one");
         end
         if (i_resp) begin
            if (i_exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL i_resp_unexpected: got i_resp=1 required 0");
            end else begin
               mon_e = i_exp_q.pop_front();
               chk("i_rdata", i_rdata, mon_e.data);
               chk("i_m_addr", 256'(m_addr), 256'(mon_e.addr));
               chk("i_m_op", 256'({m_read, m_write}), 256'(2'b10));
            end
         end
         if (d_resp) begin
            if (d_exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL d_resp_unexpected: got d_resp=1 required 0");
            end else begin
               mon_e = d_exp_q.pop_front();
               chk("d_m_addr", 256'(m_addr), 256'(mon_e.addr));
               if (mon_e.wr) begin
                  chk("d_m_op_wr", 256'({m_read, m_write}), 256'(2'b01));
                  chk("d_m_wdata", m_wdata, mon_e.data);
               end else begin
                  chk("d_m_op_rd", 256'({m_read, m_write}), 256'(2'b10));
                  chk("d_rdata", d_rdata, mon_e.data);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_m_read", 256'(m_read), 256'(0));
      chk("rst_m_write", 256'(m_write), 256'(0));
      chk("rst_m_addr", 256'(m_addr), 256'(0));
      chk("rst_m_wdata", m_wdata, 256'(0));
      chk("rst_resp", 256'({i_resp, d_resp}), 256'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Icache miss alone, then a dcache read raised during DONE.
      mem_lat = 5;
      push_i(32'h40); i_read = 1'b1; i_addr = 32'h40;
      @(negedge clk);
      chk("t1_m_read", 256'({m_read, m_write}), 256'(2'b10));
      chk("t1_m_addr", 256'(m_addr), 256'(32'h40));
      wait_resp(1'b1);
      @(negedge clk);
      chk("t1_m_read_drop", 256'({m_read, m_write}), 256'(0));
      i_read = 1'b0;
      push_d(32'h60, 1'b0, '0); d_read = 1'b1; d_addr = 32'h60;
      @(negedge clk);
      chk("t1_done_ignores", 256'({m_read, m_write}), 256'(0));
      @(negedge clk);
      chk("t1_idle_grant", 256'({m_read, m_write}), 256'(2'b10));
      chk("t1_idle_addr", 256'(m_addr), 256'(32'h60));
      wait_resp(1'b0);
      @(negedge clk);
      d_read = 1'b0;
      @(negedge clk);

      // Dcache write-back alone, inputs change mid-transaction.
      mem_lat = 4;
      push_d(32'h80, 1'b1, W1); d_write = 1'b1; d_addr = 32'h80; d_wdata = W1;
      @(negedge clk);
      chk("t3_m_op", 256'({m_read, m_write}), 256'(2'b01));
      chk("t3_m_addr", 256'(m_addr), 256'(32'h80));
      chk("t3_m_wdata", m_wdata, W1);
      d_wdata = W2; d_addr = 32'h3C0;
      wait_resp(1'b0);
      @(negedge clk);
      d_write = 1'b0;
      d_txn(32'h80, 1'b0, '0, 1);
      @(negedge clk);

      // Stray m_resp in IDLE.
      spur_cnt++;
      begin : spur_wait
         int n;
         n = 0;
         while (m_resp !== 1'b1 && n < 6) begin
            @(negedge clk);
            n++;
         end
         chk("t7_m_resp_seen", 256'(m_resp), 256'(1));
         chk("t7_no_resp", 256'({i_resp, d_resp}), 256'(0));
      end
      @(negedge clk);
      chk("t7_still_idle", 256'({m_read, m_write}), 256'(0));
      i_txn(32'h1000_0040, 1);
      @(negedge clk);

      // Asynchronous reset during D_BUSY.
      mem_lat = 6;
      push_d(32'h2000_0040, 1'b0, '0); d_read = 1'b1; d_addr = 32'h2000_0040;
      @(negedge clk);
      chk("t6_busy", 256'({m_read, m_write}), 256'(2'b10));
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_op", 256'({m_read, m_write}), 256'(0));
      chk("t6_async_addr", 256'(m_addr), 256'(0));
      d_read = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_lat = 3;
      i_txn(32'h1000_0080, 0);

      // Simultaneous requests from reset; icache wins the first conflict.
      apply_reset();
      push_i(32'h20); push_d(32'h100, 1'b0, '0);
      i_read = 1'b1; i_addr = 32'h20; d_read = 1'b1; d_addr = 32'h100;
      @(negedge clk);
      chk("t4_first_icache", 256'(m_addr), 256'(32'h20));
      wait_resp(1'b1);
      @(negedge clk);
      i_read = 1'b0;
      @(negedge clk);
      chk("t4_gap", 256'({m_read, m_write}), 256'(0));
      @(negedge clk);
      chk("t4_then_dcache", 256'(m_addr), 256'(32'h100));
      wait_resp(1'b0);
      @(negedge clk);
      d_read = 1'b0;
      // Last grant went to dcache, so a lone icache grant moves the pointer
      // toward dcache; the next conflict must go to dcache.
      i_txn(32'h1000_0000, 1);
      @(negedge clk);
      push_i(32'h1000_0020); push_d(32'h2000_0000, 1'b0, '0);
      i_read = 1'b1; i_addr = 32'h1000_0020; d_read = 1'b1; d_addr = 32'h2000_0000;
      @(negedge clk);
      chk("t4_second_dcache", 256'(m_addr), 256'(32'h2000_0000));
      wait_resp(1'b0);
      @(negedge clk);
      d_read = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t4_second_icache", 256'(m_addr), 256'(32'h1000_0020));
      wait_resp(1'b1);
      @(negedge clk);
      i_read = 1'b0;

      // Random traffic from both caches with random memory latency.
      mem_lat = 0;
      fork
         begin : i_agent
            for (int k = 0; k < 40; k++)
               i_txn(32'h1000_0000 + 32'($urandom_range(0, 63)) * 32'd32, int'($urandom_range(0, 3)));
         end
         begin : d_agent
            logic [255:0] wd;
            for (int j = 0; j < 40; j++) begin
               for (int w = 0; w < 8; w++) wd[w*32 +: 32] = $urandom;
               d_txn(32'h2000_0000 + 32'($urandom_range(0, 7)) * 32'd32, 1'($urandom_range(0, 1)),
                     wd, int'($urandom_range(0, 3)));
            end
         end
      join

      repeat (5) @(negedge clk);
      chk("mem_txn_count", 256'(txn_cnt), 256'(req_cnt));
      chk("i_queue_empty", 256'(i_exp_q.size()), 256'(0));
      chk("d_queue_empty", 256'(d_exp_q.size()), 256'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
